// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial UART transmitter between NREQ clients,
// with optional per-client lock (idle-timeout protected) and a tx_busy handshake watchdog.
module uart_tx_arbiter #(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned LOCK_TIMEOUT = 16,
   parameter int unsigned BUSY_WAIT    = 4,
   localparam int unsigned OW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_lock,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   output logic [OW-1:0]     owner,
   output logic              locked,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              err
);

   localparam int unsigned LTW = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned BTW = $clog2(BUSY_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [LTW-1:0]  lock_timer, lock_timer_nx;
   logic [BTW-1:0]  busy_timer, busy_timer_nx;

   logic [NREQ-1:0] gnt_nx;
   logic [OW-1:0]   owner_nx;
   logic            locked_nx;
   logic            tx_start_nx;
   logic [7:0]      tx_data_nx;
   logic            err_nx;

   logic [OW-1:0]   winner;
   logic            found;
   logic [OW-1:0]   grant_idx;
   logic            grant_go;
   logic [7:0]      sel_byte;

   // Round-robin scan from the slot after the last owner; a lock pins the choice to owner.
   always_comb begin
      int unsigned idx;
      winner    = owner;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = 32'(owner) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[OW'(idx)]) begin
            found  = 1'b1;
            winner = OW'(idx);
         end
      end
      grant_idx = locked ? owner : winner;
      grant_go  = (state == IDLE) && !tx_busy && (locked ? req[owner] : found);
      sel_byte  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_idx == OW'(i)) sel_byte = req_data[8*i +: 8];
      end
   end

   // State register together with all registered outputs and timers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lock_timer <= '0;
         busy_timer <= '0;
         gnt        <= '0;
         owner      <= OW'(NREQ - 1);
         locked     <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         lock_timer <= lock_timer_nx;
         busy_timer <= busy_timer_nx;
         gnt        <= gnt_nx;
         owner      <= owner_nx;
         locked     <= locked_nx;
         tx_start   <= tx_start_nx;
         tx_data    <= tx_data_nx;
         err        <= err_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant_go) state_nx = WAIT_HI;
         WAIT_HI: begin
            if (tx_busy) state_nx = WAIT_LO;
            else if (busy_timer == BTW'(BUSY_WAIT - 1)) state_nx = IDLE;
         end
         WAIT_LO: if (!tx_busy) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output and timer next values; pulses default low every cycle.
   always_comb begin
      gnt_nx        = '0;
      tx_start_nx   = 1'b0;
      err_nx        = 1'b0;
      tx_data_nx    = tx_data;
      owner_nx      = owner;
      locked_nx     = locked;
      lock_timer_nx = lock_timer;
      busy_timer_nx = busy_timer;
      case (state)
         IDLE: begin
            if (grant_go) begin
               gnt_nx        = NREQ'(1) << grant_idx;
               tx_start_nx   = 1'b1;
               tx_data_nx    = sel_byte;
               owner_nx      = grant_idx;
               locked_nx     = req_lock[grant_idx];
               lock_timer_nx = '0;
               busy_timer_nx = '0;
            end else if (locked) begin
               if (!req_lock[owner]) begin
                  locked_nx     = 1'b0;
                  lock_timer_nx = '0;
               end else if (!req[owner]) begin
                  if (lock_timer == LTW'(LOCK_TIMEOUT - 1)) begin
                     locked_nx     = 1'b0;
                     lock_timer_nx = '0;
                  end else begin
                     lock_timer_nx = lock_timer + LTW'(1);
                  end
               end
            end
         end
         WAIT_HI: begin
            if (!tx_busy) begin
               if (busy_timer == BTW'(BUSY_WAIT - 1)) begin
                  err_nx        = 1'b1;
                  locked_nx     = 1'b0;
                  busy_timer_nx = '0;
               end else begin
                  busy_timer_nx = busy_timer + BTW'(1);
               end
            end
         end
         WAIT_LO: begin
            // Packet continuation is decided by the owner's lock request at frame end.
            if (!tx_busy) locked_nx = req_lock[owner];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter model
// that raises tx_busy the cycle after tx_start and holds it for frame_len cycles.
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ         = 4;
   localparam int unsigned LOCK_TIMEOUT = 16;
   localparam int unsigned BUSY_WAIT    = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  req_lock;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        locked;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        err;

   logic [7:0]  d [4];
   int          frame_len;
   bit          model_en;
   int          busy_cnt;

   int          n_tests = 0;
   int          n_fail  = 0;

   assign req_data = {d[3], d[2], d[1], d[0]};

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NREQ(NREQ), .LOCK_TIMEOUT(LOCK_TIMEOUT), .BUSY_WAIT(BUSY_WAIT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_data(req_data),
      .gnt(gnt), .owner(owner), .locked(locked), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy), .err(err)
   );

   // Transmitter model, updated on the falling edge.
   initial begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
         end
         if (model_en && tx_start) begin
            tx_busy  = 1'b1;
            busy_cnt = frame_len;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_gnt(input int budget, output int idx, output logic [7:0] data,
                           output int cycles);
      idx    = -1;
      data   = '0;
      cycles = 0;
      while (cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (gnt != 4'b0000) break;
      end
      check("gnt_seen", 32'(gnt != 4'b0000), 32'd1);
      if (gnt != 4'b0000) begin
         for (int i = 0; i < 4; i++) if (gnt == 4'(1 << i)) idx = i;
         data = tx_data;
         check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
         check("tx_start_w_gnt", 32'(tx_start), 32'd1);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      req      = '0;
      req_lock = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic quiesce();
      int n;
      n = 0;
      while (tx_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int         idx, cyc, n;
      logic [7:0] dat;

      for (int i = 0; i < 4; i++) d[i] = 8'h00;
      frame_len = 3;
      model_en  = 1'b1;
      do_reset();

      // Reset state
      check("rst_owner", 32'(owner), 32'd3);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // Single request, long frame
      frame_len = 10;
      d[0] = 8'hA5;
      req  = 4'b0001;
      wait_gnt(5, idx, dat, cyc);
      check("single_latency", 32'(cyc), 32'd1);
      check("single_idx", 32'(idx), 32'd0);
      check("single_data", 32'(dat), 32'hA5);
      check("single_owner", 32'(owner), 32'd0);
      req = 4'b0000;
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_start) n++;
      end
      check("single_no_restart", 32'(n), 32'd0);
      d[1] = 8'hB6;
      req  = 4'b0010;
      wait_gnt(5, idx, dat, cyc);
      check("single_back_idle", 32'(cyc), 32'd1);
      check("single_next_idx", 32'(idx), 32'd1);
      req = 4'b0000;
      quiesce();

      // Round robin with all four requesting
      do_reset();
      frame_len = 3;
      for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 + i);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(20, idx, dat, cyc);
         check("rr_idx", 32'(idx), 32'(k % 4));
         check("rr_data", 32'(dat), 32'(8'h10 + (k % 4)));
      end
      req = 4'b0000;
      quiesce();

      // Lock: requester 2 keeps ownership over three bytes
      do_reset();
      d[2]     = 8'h30;
      req      = 4'b0100;
      req_lock = 4'b0100;
      wait_gnt(10, idx, dat, cyc);
      check("lock_idx1", 32'(idx), 32'd2);
      check("lock_data1", 32'(dat), 32'h30);
      check("lock_locked1", 32'(locked), 32'd1);
      d[0] = 8'h20;
      d[2] = 8'h31;
      req  = 4'b0101;
      wait_gnt(20, idx, dat, cyc);
      check("lock_idx2", 32'(idx), 32'd2);
      check("lock_data2", 32'(dat), 32'h31);
      d[2] = 8'h32;
      wait_gnt(20, idx, dat, cyc);
      check("lock_idx3", 32'(idx), 32'd2);
      check("lock_data3", 32'(dat), 32'h32);
      check("lock_locked3", 32'(locked), 32'd1);
      req_lock = 4'b0000;
      req      = 4'b0001;
      wait_gnt(20, idx, dat, cyc);
      check("unlock_idx", 32'(idx), 32'd0);
      check("unlock_data", 32'(dat), 32'h20);
      check("unlock_locked", 32'(locked), 32'd0);
      req = 4'b0000;
      quiesce();

      // Lock timeout: owner 1 idles while requester 3 waits
      do_reset();
      frame_len = 3;
      d[1]     = 8'h40;
      req      = 4'b0010;
      req_lock = 4'b0010;
      wait_gnt(10, idx, dat, cyc);
      check("to_idx1", 32'(idx), 32'd1);
      check("to_locked", 32'(locked), 32'd1);
      d[3] = 8'h50;
      req  = 4'b1000;
      n = 0;
      while (locked && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("to_unlock_cycle", 32'(n), 32'(frame_len + 1 + LOCK_TIMEOUT));
      check("to_no_gnt_yet", 32'(gnt), 32'd0);
      wait_gnt(5, idx, dat, cyc);
      check("to_gnt_latency", 32'(cyc), 32'd1);
      check("to_gnt_idx", 32'(idx), 32'd3);
      check("to_gnt_data", 32'(dat), 32'h50);
      req_lock = 4'b0000;
      req      = 4'b0000;
      quiesce();

      // tx_busy never rises
      do_reset();
      model_en = 1'b0;
      d[0]     = 8'h60;
      req      = 4'b0001;
      req_lock = 4'b0001;
      wait_gnt(5, idx, dat, cyc);
      check("err_gnt_idx", 32'(idx), 32'd0);
      check("err_locked_pre", 32'(locked), 32'd1);
      req      = 4'b0000;
      req_lock = 4'b0000;
      n = 0;
      while (!err && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("err_delay", 32'(n), 32'(BUSY_WAIT));
      check("err_locked_post", 32'(locked), 32'd0);
      @(negedge clk);
      check("err_pulse_width", 32'(err), 32'd0);
      model_en = 1'b1;
      d[2]     = 8'h61;
      req      = 4'b0100;
      wait_gnt(5, idx, dat, cyc);
      check("err_rearb_latency", 32'(cyc), 32'd1);
      check("err_rearb_idx", 32'(idx), 32'd2);
      check("err_rearb_data", 32'(dat), 32'h61);
      req = 4'b0000;
      quiesce();

      // Reset while waiting for tx_busy to fall
      do_reset();
      frame_len = 10;
      d[1]     = 8'h70;
      req      = 4'b0010;
      req_lock = 4'b0010;
      wait_gnt(5, idx, dat, cyc);
      check("mid_gnt_idx", 32'(idx), 32'd1);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_owner", 32'(owner), 32'd3);
      check("mid_locked", 32'(locked), 32'd0);
      check("mid_gnt", 32'(gnt), 32'd0);
      check("mid_tx_start", 32'(tx_start), 32'd0);
      check("mid_tx_data", 32'(tx_data), 32'd0);
      rst      = 1'b0;
      req_lock = 4'b0000;
      d[0]     = 8'h80;
      d[2]     = 8'h81;
      req      = 4'b0101;
      wait_gnt(40, idx, dat, cyc);
      check("post_rst_idx", 32'(idx), 32'd0);
      check("post_rst_data", 32'(dat), 32'h80);
      req = 4'b0000;
      quiesce();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
